inv_sub_bytes_seq: RTL and testbench



---
 rtl/aes_pkg.sv | 15 +
 rtl/inv_sbox.sv | 47 ++++
 rtl/inv_sub_bytes_seq.sv | 91 +++++++++
 tb/tb_inv_sub_bytes_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES widths, FSM state encoding and byte-select helper.
// No ports. Byte 0 of a state is the most significant byte [127:120].
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NBYTES  = 16;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_state_e;

    function automatic logic [AES_BYTE_W-1:0] get_byte(input logic [AES_STATE_W-1:0] s, input int i);
        return s[AES_STATE_W-1-AES_BYTE_W*i -: AES_BYTE_W];
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// inv_sbox: combinational FIPS-197 inverse S-box.
// Ports: in_byte (8, in) byte to substitute; out_byte (8, out) InvSbox(in_byte).
module inv_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    always_comb begin
        out_byte = 8'h00;
        case (in_byte)
            8'h00: out_byte = 8'h52; 8'h01: out_byte = 8'h09; 8'h02: out_byte = 8'h6a; 8'h03: out_byte = 8'hd5; 8'h04: out_byte = 8'h30; 8'h05: out_byte = 8'h36; 8'h06: out_byte = 8'ha5; 8'h07: out_byte = 8'h38;
            8'h08: out_byte = 8'hbf; 8'h09: out_byte = 8'h40; 8'h0a: out_byte = 8'ha3; 8'h0b: out_byte = 8'h9e; 8'h0c: out_byte = 8'h81; 8'h0d: out_byte = 8'hf3; 8'h0e: out_byte = 8'hd7; 8'h0f: out_byte = 8'hfb;
            8'h10: out_byte = 8'h7c; 8'h11: out_byte = 8'he3; 8'h12: out_byte = 8'h39; 8'h13: out_byte = 8'h82; 8'h14: out_byte = 8'h9b; 8'h15: out_byte = 8'h2f; 8'h16: out_byte = 8'hff; 8'h17: out_byte = 8'h87;
            8'h18: out_byte = 8'h34; 8'h19: out_byte = 8'h8e; 8'h1a: out_byte = 8'h43; 8'h1b: out_byte = 8'h44; 8'h1c: out_byte = 8'hc4; 8'h1d: out_byte = 8'hde; 8'h1e: out_byte = 8'he9; 8'h1f: out_byte = 8'hcb;
            8'h20: out_byte = 8'h54; 8'h21: out_byte = 8'h7b; 8'h22: out_byte = 8'h94; 8'h23: out_byte = 8'h32; 8'h24: out_byte = 8'ha6; 8'h25: out_byte = 8'hc2; 8'h26: out_byte = 8'h23; 8'h27: out_byte = 8'h3d;
            8'h28: out_byte = 8'hee; 8'h29: out_byte = 8'h4c; 8'h2a: out_byte = 8'h95; 8'h2b: out_byte = 8'h0b; 8'h2c: out_byte = 8'h42; 8'h2d: out_byte = 8'hfa; 8'h2e: out_byte = 8'hc3; 8'h2f: out_byte = 8'h4e;
            8'h30: out_byte = 8'h08; 8'h31: out_byte = 8'h2e; 8'h32: out_byte = 8'ha1; 8'h33: out_byte = 8'h66; 8'h34: out_byte = 8'h28; 8'h35: out_byte = 8'hd9; 8'h36: out_byte = 8'h24; 8'h37: out_byte = 8'hb2;
            8'h38: out_byte = 8'h76; 8'h39: out_byte = 8'h5b; 8'h3a: out_byte = 8'ha2; 8'h3b: out_byte = 8'h49; 8'h3c: out_byte = 8'h6d; 8'h3d: out_byte = 8'h8b; 8'h3e: out_byte = 8'hd1; 8'h3f: out_byte = 8'h25;
            8'h40: out_byte = 8'h72; 8'h41: out_byte = 8'hf8; 8'h42: out_byte = 8'hf6; 8'h43: out_byte = 8'h64; 8'h44: out_byte = 8'h86; 8'h45: out_byte = 8'h68; 8'h46: out_byte = 8'h98; 8'h47: out_byte = 8'h16;
            8'h48: out_byte = 8'hd4; 8'h49: out_byte = 8'ha4; 8'h4a: out_byte = 8'h5c; 8'h4b: out_byte = 8'hcc; 8'h4c: out_byte = 8'h5d; 8'h4d: out_byte = 8'h65; 8'h4e: out_byte = 8'hb6; 8'h4f: out_byte = 8'h92;
            8'h50: out_byte = 8'h6c; 8'h51: out_byte = 8'h70; 8'h52: out_byte = 8'h48; 8'h53: out_byte = 8'h50; 8'h54: out_byte = 8'hfd; 8'h55: out_byte = 8'hed; 8'h56: out_byte = 8'hb9; 8'h57: out_byte = 8'hda;
            8'h58: out_byte = 8'h5e; 8'h59: out_byte = 8'h15; 8'h5a: out_byte = 8'h46; 8'h5b: out_byte = 8'h57; 8'h5c: out_byte = 8'ha7; 8'h5d: out_byte = 8'h8d; 8'h5e: out_byte = 8'h9d; 8'h5f: out_byte = 8'h84;
            8'h60: out_byte = 8'h90; 8'h61: out_byte = 8'hd8; 8'h62: out_byte = 8'hab; 8'h63: out_byte = 8'h00; 8'h64: out_byte = 8'h8c; 8'h65: out_byte = 8'hbc; 8'h66: out_byte = 8'hd3; 8'h67: out_byte = 8'h0a;
            8'h68: out_byte = 8'hf7; 8'h69: out_byte = 8'he4; 8'h6a: out_byte = 8'h58; 8'h6b: out_byte = 8'h05; 8'h6c: out_byte = 8'hb8; 8'h6d: out_byte = 8'hb3; 8'h6e: out_byte = 8'h45; 8'h6f: out_byte = 8'h06;
            8'h70: out_byte = 8'hd0; 8'h71: out_byte = 8'h2c; 8'h72: out_byte = 8'h1e; 8'h73: out_byte = 8'h8f; 8'h74: out_byte = 8'hca; 8'h75: out_byte = 8'h3f; 8'h76: out_byte = 8'h0f; 8'h77: out_byte = 8'h02;
            8'h78: out_byte = 8'hc1; 8'h79: out_byte = 8'haf; 8'h7a: out_byte = 8'hbd; 8'h7b: out_byte = 8'h03; 8'h7c: out_byte = 8'h01; 8'h7d: out_byte = 8'h13; 8'h7e: out_byte = 8'h8a; 8'h7f: out_byte = 8'h6b;
            8'h80: out_byte = 8'h3a; 8'h81: out_byte = 8'h91; 8'h82: out_byte = 8'h11; 8'h83: out_byte = 8'h41; 8'h84: out_byte = 8'h4f; 8'h85: out_byte = 8'h67; 8'h86: out_byte = 8'hdc; 8'h87: out_byte = 8'hea;
            8'h88: out_byte = 8'h97; 8'h89: out_byte = 8'hf2; 8'h8a: out_byte = 8'hcf; 8'h8b: out_byte = 8'hce; 8'h8c: out_byte = 8'hf0; 8'h8d: out_byte = 8'hb4; 8'h8e: out_byte = 8'he6; 8'h8f: out_byte = 8'h73;
            8'h90: out_byte = 8'h96; 8'h91: out_byte = 8'hac; 8'h92: out_byte = 8'h74; 8'h93: out_byte = 8'h22; 8'h94: out_byte = 8'he7; 8'h95: out_byte = 8'had; 8'h96: out_byte = 8'h35; 8'h97: out_byte = 8'h85;
            8'h98: out_byte = 8'he2; 8'h99: out_byte = 8'hf9; 8'h9a: out_byte = 8'h37; 8'h9b: out_byte = 8'he8; 8'h9c: out_byte = 8'h1c; 8'h9d: out_byte = 8'h75; 8'h9e: out_byte = 8'hdf; 8'h9f: out_byte = 8'h6e;
            8'ha0: out_byte = 8'h47; 8'ha1: out_byte = 8'hf1; 8'ha2: out_byte = 8'h1a; 8'ha3: out_byte = 8'h71; 8'ha4: out_byte = 8'h1d; 8'ha5: out_byte = 8'h29; 8'ha6: out_byte = 8'hc5; 8'ha7: out_byte = 8'h89;
            8'ha8: out_byte = 8'h6f; 8'ha9: out_byte = 8'hb7; 8'haa: out_byte = 8'h62; 8'hab: out_byte = 8'h0e; 8'hac: out_byte = 8'haa; 8'had: out_byte = 8'h18; 8'hae: out_byte = 8'hbe; 8'haf: out_byte = 8'h1b;
            8'hb0: out_byte = 8'hfc; 8'hb1: out_byte = 8'h56; 8'hb2: out_byte = 8'h3e; 8'hb3: out_byte = 8'h4b; 8'hb4: out_byte = 8'hc6; 8'hb5: out_byte = 8'hd2; 8'hb6: out_byte = 8'h79; 8'hb7: out_byte = 8'h20;
            8'hb8: out_byte = 8'h9a; 8'hb9: out_byte = 8'hdb; 8'hba: out_byte = 8'hc0; 8'hbb: out_byte = 8'hfe; 8'hbc: out_byte = 8'h78; 8'hbd: out_byte = 8'hcd; 8'hbe: out_byte = 8'h5a; 8'hbf: out_byte = 8'hf4;
            8'hc0: out_byte = 8'h1f; 8'hc1: out_byte = 8'hdd; 8'hc2: out_byte = 8'ha8; 8'hc3: out_byte = 8'h33; 8'hc4: out_byte = 8'h88; 8'hc5: out_byte = 8'h07; 8'hc6: out_byte = 8'hc7; 8'hc7: out_byte = 8'h31;
            8'hc8: out_byte = 8'hb1; 8'hc9: out_byte = 8'h12; 8'hca: out_byte = 8'h10; 8'hcb: out_byte = 8'h59; 8'hcc: out_byte = 8'h27; 8'hcd: out_byte = 8'h80; 8'hce: out_byte = 8'hec; 8'hcf: out_byte = 8'h5f;
            8'hd0: out_byte = 8'h60; 8'hd1: out_byte = 8'h51; 8'hd2: out_byte = 8'h7f; 8'hd3: out_byte = 8'ha9; 8'hd4: out_byte = 8'h19; 8'hd5: out_byte = 8'hb5; 8'hd6: out_byte = 8'h4a; 8'hd7: out_byte = 8'h0d;
            8'hd8: out_byte = 8'h2d; 8'hd9: out_byte = 8'he5; 8'hda: out_byte = 8'h7a; 8'hdb: out_byte = 8'h9f; 8'hdc: out_byte = 8'h93; 8'hdd: out_byte = 8'hc9; 8'hde: out_byte = 8'h9c; 8'hdf: out_byte = 8'hef;
            8'he0: out_byte = 8'ha0; 8'he1: out_byte = 8'he0; 8'he2: out_byte = 8'h3b; 8'he3: out_byte = 8'h4d; 8'he4: out_byte = 8'hae; 8'he5: out_byte = 8'h2a; 8'he6: out_byte = 8'hf5; 8'he7: out_byte = 8'hb0;
            8'he8: out_byte = 8'hc8; 8'he9: out_byte = 8'heb; 8'hea: out_byte = 8'hbb; 8'heb: out_byte = 8'h3c; 8'hec: out_byte = 8'h83; 8'hed: out_byte = 8'h53; 8'hee: out_byte = 8'h99; 8'hef: out_byte = 8'h61;
            8'hf0: out_byte = 8'h17; 8'hf1: out_byte = 8'h2b; 8'hf2: out_byte = 8'h04; 8'hf3: out_byte = 8'h7e; 8'hf4: out_byte = 8'hba; 8'hf5: out_byte = 8'h77; 8'hf6: out_byte = 8'hd6; 8'hf7: out_byte = 8'h26;
            8'hf8: out_byte = 8'he1; 8'hf9: out_byte = 8'h69; 8'hfa: out_byte = 8'h14; 8'hfb: out_byte = 8'h63; 8'hfc: out_byte = 8'h55; 8'hfd: out_byte = 8'h21; 8'hfe: out_byte = 8'h0c; 8'hff: out_byte = 8'h7d;
            default: out_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: iterative InvSubBytes, BYTES_PER_CYCLE bytes per clock through shared inverse S-boxes.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data (128-bit state from inverse ShiftRows);
//        out_valid/out_ready/out_data (substituted state, held until accepted); busy (high while substituting).
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data,
    output logic                   busy
);

    localparam int NCYC = AES_NBYTES / BYTES_PER_CYCLE;
    localparam int CW   = NCYC > 1 ? $clog2(NCYC) : 1;

    fsm_state_e             state_q, state_d;
    logic [AES_STATE_W-1:0] work_q, work_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   in_ready_q, out_valid_q, busy_q;
    logic [3:0]             base;
    logic                   last;
    logic [AES_BYTE_W-1:0]  sb_in  [BYTES_PER_CYCLE];
    logic [AES_BYTE_W-1:0]  sb_out [BYTES_PER_CYCLE];

    // First byte index of the chunk handled this cycle.
    assign base = 4'(int'(cnt_q) * BYTES_PER_CYCLE);
    assign last = int'(cnt_q) == NCYC - 1;

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
        assign sb_in[g] = get_byte(work_q, int'(base) + g);
        inv_sbox u_inv_sbox (
            .in_byte (sb_in[g]),
            .out_byte(sb_out[g])
        );
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int i = 0; i < BYTES_PER_CYCLE; i++)
                    work_d[AES_STATE_W-1-AES_BYTE_W*(int'(base)+i) -: AES_BYTE_W] = sb_out[i];
                cnt_d   = last ? '0 : cnt_q + 1'b1;
                state_d = last ? DONE : BUSY;
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they change only on clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= state_d == IDLE;
            out_valid_q <= state_d == DONE;
            busy_q      <= state_d == BUSY;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = work_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb_inv_sub_bytes_seq: directed and random checks of inv_sub_bytes_seq against an algebraic inverse S-box model.
module tb_inv_sub_bytes_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] in_data = '0;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_data;

    logic [3:0]   v_iv = 4'h0;
    logic [3:0]   v_or = 4'hf;
    logic [3:0]   v_ir, v_ov, v_bz;
    logic [127:0] v_od [4];

    int n_vec = 0;
    int n_err = 0;
    int pushed = 0;
    int popped = 0;
    logic [127:0] sb_q [$];
    logic [7:0]   inv_tab [256];

    always #5 clk = ~clk;

    inv_sub_bytes_seq u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    for (genvar g = 0; g < 4; g++) begin : g_var
        inv_sub_bytes_seq #(.BYTES_PER_CYCLE(g < 2 ? (1 << g) : (1 << (g + 1)))) u_var (
            .clk(clk), .rst_n(rst_n), .in_valid(v_iv[g]), .in_ready(v_ir[g]), .in_data(in_data),
            .out_valid(v_ov[g]), .out_ready(v_or[g]), .out_data(v_od[g]), .busy(v_bz[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // Forward S-box from GF(2^8) inverse plus affine map; the inverse table is its preimage.
    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_tab[d[127-8*i -: 8]];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d, output int lat);
        chk("in_ready_idle", 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        in_data  = d;
        sb_q.push_back(model(d));
        pushed++;
        step();
        in_valid = 1'b0;
        chk("busy_after_accept", 128'(busy), 128'(1));
        chk("in_ready_busy", 128'(in_ready), 128'(0));
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    // Scoreboard: pop on every output handshake and check stability while stalled.
    logic         stall_q = 1'b0;
    logic [127:0] held_q = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q) begin
                chk("stall_valid", 128'(out_valid), 128'(1));
                chk("stall_data", out_data, held_q);
            end
            if (out_valid && out_ready) begin
                chk("q_nonempty", 128'(sb_q.size() != 0), 128'(1));
                if (sb_q.size() != 0) chk("sb_data", out_data, sb_q.pop_front());
                popped++;
            end
            stall_q <= out_valid && !out_ready;
            held_q  <= out_data;
        end
    end

    initial begin
        int lat;
        int vlat [4];
        bit seen [4];
        int acc;
        int cyc;
        logic [127:0] c1_in  = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
        logic [127:0] c1_out = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
        for (int x = 0; x < 256; x++) inv_tab[fwd_sbox(8'(x))] = 8'(x);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));

        out_ready = 1'b1;
        send(128'(0), lat);
        chk("zero_lat", 128'(lat), 128'(4));
        chk("zero_data", out_data, {16{8'h52}});
        step();
        chk("zero_ov_one_cycle", 128'(out_valid), 128'(0));
        chk("zero_in_ready_back", 128'(in_ready), 128'(1));

        send(c1_in, lat);
        chk("c1_lat", 128'(lat), 128'(4));
        chk("c1_data", out_data, c1_out);
        step();

        in_data = c1_in;
        v_iv = 4'hf;
        step();
        v_iv = 4'h0;
        for (int g = 0; g < 4; g++) begin seen[g] = 1'b0; vlat[g] = 0; end
        for (int c = 1; c <= 20; c++) begin
            step();
            for (int g = 0; g < 4; g++) if (!seen[g] && v_ov[g]) begin
                seen[g] = 1'b1;
                vlat[g] = c;
                chk("var_data", v_od[g], c1_out);
            end
        end
        for (int g = 0; g < 4; g++) chk("var_lat", 128'(vlat[g]), 128'(16 / (g < 2 ? (1 << g) : (1 << (g + 1)))));

        out_ready = 1'b0;
        send({16{8'h63}}, lat);
        chk("bp_lat", 128'(lat), 128'(4));
        for (int c = 0; c < 10; c++) begin
            step();
            chk("bp_out_valid", 128'(out_valid), 128'(1));
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            chk("bp_data", out_data, 128'(0));
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_ov", 128'(out_valid), 128'(0));
        chk("bp_release_ir", 128'(in_ready), 128'(1));

        in_valid = 1'b1;
        in_data  = {16{8'h16}};
        sb_q.push_back(model(in_data));
        pushed++;
        out_ready = 1'b0;
        step();
        lat = 0;
        while (!out_valid && lat < 40) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            step();
            lat++;
        end
        chk("hold_lat", 128'(lat), 128'(4));
        repeat (3) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        chk("hold_first_only", out_data, {16{8'hff}});
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("hold_in_ready", 128'(in_ready), 128'(1));
        send({16{8'hff}}, lat);
        chk("ff_lat", 128'(lat), 128'(4));
        chk("ff_data", out_data, {16{8'h7d}});
        step();

        in_valid = 1'b1;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        step();
        in_valid = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'(0));
        chk("arst_in_ready", 128'(in_ready), 128'(1));
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_data", out_data, 128'(0));
        step();
        rst_n = 1'b1;
        step();
        send({16{8'h01}}, lat);
        chk("post_rst_lat", 128'(lat), 128'(4));
        chk("post_rst_data", out_data, {16{8'h09}});
        step();

        acc = 0;
        cyc = 0;
        while (acc < 1000 && cyc < 60000) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = $urandom_range(0, 3) != 0;
            if (in_valid && in_ready) begin
                sb_q.push_back(model(in_data));
                pushed++;
                acc++;
            end
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 100) begin
            step();
            cyc++;
        end
        step();
        chk("rand_accepted", 128'(acc), 128'(1000));
        chk("rand_drained", 128'(sb_q.size()), 128'(0));
        chk("rand_no_loss_dup", 128'(popped), 128'(pushed));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
